// File: rtl/led_band_fc_chain_setter.sv
// FC word writer for daisy-chained LED band drivers: decodes FCWRTEN/WRTFC from LAT/SCLK
// and shifts a snapshot of each band's FC word onto its SOUT line, once per chained driver.
module led_band_fc_chain_setter #(
    parameter int unsigned N_BANDS       = 4,
    parameter int unsigned N_CHAIN       = 2,
    parameter int unsigned FC_W          = 48,
    parameter int unsigned FCWRTEN_EDGES = 15,
    parameter int unsigned WRTFC_EDGES   = 5,
    parameter logic [FC_W-1:0] DEFAULT_FC = 48'h5c0201008048,
    parameter int unsigned ADDR_W        = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCLK,
    input  logic               LAT,
    output logic [N_BANDS-1:0] SOUT,
    output logic               en,
    input  logic [ADDR_W-1:0]  hps_fc_addr,
    input  logic [FC_W-1:0]    hps_fc_data,
    input  logic               hps_fc_write,
    input  logic               hps_err_clr,
    output logic               fc_err_short,
    output logic               fc_err_overrun,
    output logic               busy
);
    localparam int unsigned CNT_MAX = ((FCWRTEN_EDGES > WRTFC_EDGES) ? FCWRTEN_EDGES : WRTFC_EDGES) + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = (FC_W > 1) ? $clog2(FC_W) : 1;
    localparam int unsigned CH_W    = (N_CHAIN > 1) ? $clog2(N_CHAIN) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_WRT} state_t;

    state_t            state, state_next;
    logic [FC_W-1:0]   fc     [N_BANDS];
    logic [FC_W-1:0]   shadow [N_BANDS];
    logic [BIT_W-1:0]  bit_idx;
    logic [CH_W-1:0]   chain_idx;
    logic [CNT_W-1:0]  lat_cnt;
    logic              prev_sclk;
    logic              posedge_sclk, shift_edge, fcwrten, wrtfc, last_bit;

    assign posedge_sclk = SCLK & ~prev_sclk;
    assign shift_edge   = posedge_sclk & ~LAT;
    // Counter still holds its pre-clear value on the first LAT-low cycle.
    assign fcwrten      = ~LAT & (lat_cnt == CNT_W'(FCWRTEN_EDGES));
    assign wrtfc        = ~LAT & (lat_cnt == CNT_W'(WRTFC_EDGES));
    assign last_bit     = (bit_idx == '0) & (chain_idx == CH_W'(N_CHAIN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sclk <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            prev_sclk <= SCLK;
            if (!LAT)
                lat_cnt <= '0;
            else if (posedge_sclk && lat_cnt != '1)
                lat_cnt <= lat_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned b = 0; b < N_BANDS; b++)
                fc[b] <= DEFAULT_FC;
        end else if (hps_fc_write) begin
            for (int unsigned b = 0; b < N_BANDS; b++)
                if (hps_fc_addr == ADDR_W'(b))
                    fc[b] <= hps_fc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            en    <= 1'b1;
        end else begin
            state <= state_next;
            en    <= (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (fcwrten) state_next = SHIFT;
            SHIFT:    if (wrtfc) state_next = IDLE;
                      else if (shift_edge && last_bit) state_next = WAIT_WRT;
            WAIT_WRT: if (wrtfc) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        for (int unsigned b = 0; b < N_BANDS; b++)
            SOUT[b] = (state == SHIFT) ? shadow[b][bit_idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx   <= '0;
            chain_idx <= '0;
            for (int unsigned b = 0; b < N_BANDS; b++)
                shadow[b] <= '0;
        end else begin
            if (state == IDLE && fcwrten) begin
                for (int unsigned b = 0; b < N_BANDS; b++)
                    shadow[b] <= fc[b];
                bit_idx   <= BIT_W'(FC_W - 1);
                chain_idx <= '0;
            end else if (state == SHIFT && !wrtfc && shift_edge) begin
                if (bit_idx != '0) begin
                    bit_idx <= bit_idx - BIT_W'(1);
                end else if (chain_idx != CH_W'(N_CHAIN - 1)) begin
                    bit_idx   <= BIT_W'(FC_W - 1);
                    chain_idx <= chain_idx + CH_W'(1);
                end
            end
        end
    end

    // Set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_err_short   <= 1'b0;
            fc_err_overrun <= 1'b0;
        end else begin
            if (state == SHIFT && wrtfc)
                fc_err_short <= 1'b1;
            else if (hps_err_clr)
                fc_err_short <= 1'b0;
            if (state == WAIT_WRT && shift_edge)
                fc_err_overrun <= 1'b1;
            else if (hps_err_clr)
                fc_err_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_led_band_fc_chain_setter.sv
// Scoreboard bench: expected SOUT pairs are queued from a bench-side FC model at each
// FCWRTEN and popped as each SCLK edge is issued.
module tb_led_band_fc_chain_setter;
    localparam int NB = 2;
    localparam int FW = 48;
    localparam logic [FW-1:0] DEF = 48'h5c0201008048;

    logic          clk = 1'b0;
    logic          rst, SCLK, LAT, hps_fc_write, hps_err_clr;
    logic [NB-1:0] SOUT;
    logic          en, fc_err_short, fc_err_overrun, busy;
    logic [1:0]    hps_fc_addr;
    logic [FW-1:0] hps_fc_data;

    int total = 0;
    int bad   = 0;
    logic [FW-1:0] model [NB];
    logic [NB-1:0] exp_q [$];

    led_band_fc_chain_setter #(
        .N_BANDS(NB), .N_CHAIN(2), .FC_W(FW), .FCWRTEN_EDGES(15),
        .WRTFC_EDGES(5), .DEFAULT_FC(DEF), .ADDR_W(2)
    ) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT), .en(en),
        .hps_fc_addr(hps_fc_addr), .hps_fc_data(hps_fc_data),
        .hps_fc_write(hps_fc_write), .hps_err_clr(hps_err_clr),
        .fc_err_short(fc_err_short), .fc_err_overrun(fc_err_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclk_pulse();
        SCLK = 1'b1; tick();
        SCLK = 1'b0; tick();
    endtask

    task automatic lat_cmd(input int n);
        LAT = 1'b1; tick();
        repeat (n) sclk_pulse();
        LAT = 1'b0; tick();
    endtask

    task automatic fc_write(input logic [1:0] a, input logic [FW-1:0] d);
        hps_fc_addr = a; hps_fc_data = d; hps_fc_write = 1'b1; tick();
        hps_fc_write = 1'b0;
        if (int'(a) < NB) model[a] = d;
    endtask

    task automatic start_xfer();
        logic [NB-1:0] e;
        exp_q.delete();
        for (int c = 0; c < 2; c++)
            for (int k = FW - 1; k >= 0; k--) begin
                for (int b = 0; b < NB; b++) e[b] = model[b][k];
                exp_q.push_back(e);
            end
        lat_cmd(15);
        chk("start_en", en, 0);
        chk("start_busy", busy, 1);
    endtask

    // wr_at: edge index for a band-0 write of zero; rst_at: edge index for a reset.
    task automatic shift_edges(input int n, input int wr_at, input int rst_at);
        logic [NB-1:0] e;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) fc_write(2'd0, '0);
            if (i == rst_at) begin
                rst = 1'b1; tick(); rst = 1'b0;
                for (int b = 0; b < NB; b++) model[b] = DEF;
                exp_q.delete();
                return;
            end
            if (exp_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sout", SOUT, e);
            end
            chk("en_low", en, 0);
            sclk_pulse();
        end
    endtask

    initial begin
        rst = 1'b1; SCLK = 1'b0; LAT = 1'b0; hps_fc_write = 1'b0; hps_err_clr = 1'b0;
        hps_fc_addr = '0; hps_fc_data = '0;
        for (int b = 0; b < NB; b++) model[b] = DEF;
        tick(); tick(); rst = 1'b0;
        chk("rst_en", en, 1);
        chk("rst_sout", SOUT, 0);
        chk("rst_busy", busy, 0);
        chk("rst_short", fc_err_short, 0);
        chk("rst_over", fc_err_overrun, 0);

        // Full transfer of two known words
        fc_write(2'd0, 48'hA5A5_0000_FFFF);
        fc_write(2'd1, 48'h0123_4567_89AB);
        start_xfer();
        shift_edges(96, -1, -1);
        chk("wait_busy", busy, 1);
        chk("wait_sout", SOUT, 0);
        chk("wait_en", en, 0);
        lat_cmd(5);
        chk("done_en", en, 1);
        chk("done_busy", busy, 0);
        chk("done_short", fc_err_short, 0);
        chk("done_over", fc_err_overrun, 0);

        // Mid-shift write must not disturb the snapshot; extra edges flag overrun
        start_xfer();
        shift_edges(96, 20, -1);
        sclk_pulse(); sclk_pulse();
        chk("over_flag", fc_err_overrun, 1);
        chk("over_busy", busy, 1);
        lat_cmd(5);
        chk("over_en", en, 1);
        chk("over_keep", fc_err_overrun, 1);
        hps_err_clr = 1'b1; tick(); hps_err_clr = 1'b0;
        chk("over_clr", fc_err_overrun, 0);

        // Out-of-range address is ignored; next transfer carries the zero word
        fc_write(2'd3, 48'hDEAD_BEEF_CAFE);
        start_xfer();
        shift_edges(40, -1, -1);
        lat_cmd(5);
        chk("short_flag", fc_err_short, 1);
        chk("short_en", en, 1);
        chk("short_busy", busy, 0);
        hps_err_clr = 1'b1; tick(); hps_err_clr = 1'b0;
        chk("short_clr", fc_err_short, 0);

        // WRTFC in IDLE does nothing
        lat_cmd(5);
        chk("idle_wrtfc_en", en, 1);
        chk("idle_wrtfc_short", fc_err_short, 0);

        // Reset mid-shift aborts and restores defaults
        start_xfer();
        shift_edges(96, -1, 50);
        chk("mrst_en", en, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_sout", SOUT, 0);
        chk("mrst_short", fc_err_short, 0);
        start_xfer();
        shift_edges(96, -1, -1);
        lat_cmd(5);
        chk("final_en", en, 1);
        chk("final_over", fc_err_overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_band_fc_chain_setter.md
Name: led_band_fc_chain_setter

Overview:
- Next-generation FC (function control) writer for the LED band drivers.
- Holds one FC word per LED band, loaded by the HPS through an address/data/write port.
- Detects the FCWRTEN latch command decoded from LAT/SCLK. It then shifts each band's FC word onto that band's SOUT line, MSB first, once per daisy-chained driver. It returns control to the grayscale path on WRTFC.
- Adds over the previous generation: multiple bands, multi-driver chains, a snapshot shadow register, and sticky sequence-error reporting.

Parameters:
- N_BANDS, 4, number of independent LED bands; one SOUT bit each.
- N_CHAIN, 2, drivers daisy-chained per band; each FC word is shifted N_CHAIN times back-to-back.
- FC_W, 48, FC word width in bits.
- FCWRTEN_EDGES, 15, SCLK rising edges while LAT high that decode as FCWRTEN.
- WRTFC_EDGES, 5, SCLK rising edges while LAT high that decode as WRTFC.
- DEFAULT_FC, 48'h5c0201008048, reset value of every band's FC register; FC_W bits wide.
- ADDR_W, 2, HPS address width; must satisfy 2^ADDR_W >= N_BANDS.

Ports:
- clk  in  1  system clock; SCLK and LAT are sampled on it.
- rst  in  1  synchronous active-high reset.
- SCLK  in  1  driver shift clock, already synchronous to clk.
- LAT  in  1  driver latch line.
- SOUT  out  N_BANDS  per-band serial FC data.
- en  out  1  high = grayscale path owns SOUT; low = this block is writing FC.
- hps_fc_addr  in  ADDR_W  band index for an HPS write.
- hps_fc_data  in  FC_W  FC word to write.
- hps_fc_write  in  1  single-cycle write strobe.
- hps_err_clr  in  1  clears the sticky error flags.
- fc_err_short  out  1  sticky: WRTFC arrived before all bits were shifted.
- fc_err_overrun  out  1  sticky: extra SCLK edges with LAT low after all bits were shifted.
- busy  out  1  high in SHIFT and WAIT_WRT.

Behaviour:
- Reset (rst high at a clk edge):
  - all FC registers <= DEFAULT_FC; state <= IDLE; en = 1; SOUT = 0.
  - busy = 0; both error flags = 0; all counters = 0.
  - Reset mid-shift aborts the transfer immediately.
- FC registers:
  - on hps_fc_write, FC[hps_fc_addr] <= hps_fc_data the following cycle.
  - addr >= N_BANDS: write ignored.
  - writes are accepted in any state and never affect a transfer in progress (shadow registers are used).
- SCLK edge detection: posedge_SCLK = SCLK & ~prev_SCLK, with prev_SCLK registered on clk.
- LAT edge counter:
  - increments on posedge_SCLK while LAT=1; cleared on any cycle with LAT=0.
  - wide enough to count max(FCWRTEN_EDGES, WRTFC_EDGES) + 1.
  - saturates at its maximum value; no wrap.
- Decodes, each valid for one cycle when LAT=0 and the counter still holds its pre-clear value:
  - FCWRTEN = ~LAT & (cnt == FCWRTEN_EDGES).
  - WRTFC = ~LAT & (cnt == WRTFC_EDGES).
- State machine (IDLE, SHIFT, WAIT_WRT):
  - IDLE:
    - SOUT = 0, en = 1.
    - On FCWRTEN: shadow[b] <= FC[b] for all b; bit_idx <= FC_W-1; chain_idx <= 0; en <= 0; go to SHIFT.
    - WRTFC in IDLE is ignored.
  - SHIFT:
    - SOUT[b] = shadow[b][bit_idx], combinational from registers.
    - Each posedge_SCLK with LAT=0:
      - if bit_idx > 0: bit_idx decrements.
      - if bit_idx == 0 and chain_idx < N_CHAIN-1: bit_idx <= FC_W-1 and chain_idx increments.
      - if bit_idx == 0 and chain_idx == N_CHAIN-1: go to WAIT_WRT.
    - Total edges consumed = N_CHAIN*FC_W.
    - WRTFC while in SHIFT: set fc_err_short, en <= 1, go to IDLE.
  - WAIT_WRT:
    - SOUT = 0.
    - On WRTFC: en <= 1, go to IDLE.
    - Any posedge_SCLK with LAT=0: set fc_err_overrun and stay in WAIT_WRT.
    - FCWRTEN in WAIT_WRT or SHIFT: ignored.
- Error flags:
  - sticky until hps_err_clr.
  - if a set condition and hps_err_clr occur in the same cycle, set wins.
- busy = (state != IDLE).

Test Plan:
- Reset with N_BANDS=2, N_CHAIN=2 -> en=1, SOUT=2'b00, busy=0, both error flags 0.
- Write FC[0]=48'hA5A5_0000_FFFF and FC[1]=48'h0123_4567_89AB; LAT high for 15 SCLK edges, then low; then 96 SCLK edges; then LAT high for 5 edges and low -> en=0 for the whole transfer.
  - SOUT[0] carries A5A50000FFFF twice, MSB first; SOUT[1] carries 0123456789AB twice.
  - en=1 on the cycle after WRTFC; no error flags set.
- hps_fc_write to band 0 with 48'h0 at edge 20 of the shift -> remaining SOUT[0] bits still come from A5A50000FFFF; the next FCWRTEN transfers 48'h0.
- WRTFC issued after only 40 SCLK edges -> fc_err_short=1, en=1, state IDLE; hps_err_clr pulse -> flag returns to 0.
- 98 SCLK edges with LAT low before WRTFC -> fc_err_overrun=1; WRTFC still returns en to 1.
- hps_fc_write with addr=3 when N_BANDS=2 -> no FC register changes.
- rst asserted at edge 50 of a shift -> state IDLE, en=1, SOUT=0, FC registers back to DEFAULT_FC.
